// File: rtl/dead_pixel_corrector.sv
// Replaces flagged dead pixels with the rounded average of their usable horizontal
// neighbours, counts corrections per frame and flags out-of-order stream input.
module dead_pixel_corrector #(
  parameter int             W    = 32,
  parameter int             H    = 24,
  parameter int             DW   = 16,
  parameter logic [DW-1:0]  FILL = '0
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          pix_valid,
  input  logic [DW-1:0] pix_data,
  input  logic [6:0]    pix_x,
  input  logic [5:0]    pix_y,
  input  logic          pix_dead,
  output logic          out_valid,
  output logic [DW-1:0] out_data,
  output logic [6:0]    out_x,
  output logic [5:0]    out_y,
  output logic          out_corrected,
  output logic          frame_done,
  output logic [7:0]    corr_count,
  output logic          proto_err
);

  localparam logic [6:0] LAST_X = 7'(W - 1);
  localparam logic [5:0] LAST_Y = 6'(H - 1);

  // state | meaning
  // IDLE  | no pixel held
  // HOLD  | held pixel waits for its right neighbour
  // FLUSH | held pixel ends its row, emitted on the next clock
  typedef enum logic [1:0] {IDLE, HOLD, FLUSH} stateT;

  stateT         state;
  logic [DW-1:0] curData;
  logic [6:0]    curX;
  logic [5:0]    curY;
  logic          curDead;
  logic          curLeftOk;
  logic [7:0]    count;

  logic          emit;
  logic          rightHit;
  logic          leftUse;
  logic          rightUse;
  logic          lastPix;
  logic [DW:0]   avgSum;
  logic [DW-1:0] emitData;
  logic [7:0]    countNext;

  // out_data doubles as LEFT: it always holds the most recently emitted pixel.
  always_comb begin
    emit      = (state == FLUSH) || ((state == HOLD) && pix_valid);
    rightHit  = (state == HOLD) && pix_valid && (pix_x == curX + 7'd1);
    leftUse   = curLeftOk && (curX != 7'd0);
    rightUse  = rightHit && !pix_dead;
    avgSum    = {1'b0, out_data} + {1'b0, pix_data} + (DW+1)'(1);
    emitData  = curData;
    if (curDead) begin
      if (leftUse && rightUse) emitData = avgSum[DW:1];
      else if (leftUse)        emitData = out_data;
      else if (rightUse)       emitData = pix_data;
      else                     emitData = FILL;
    end
    countNext = (emit && curDead && (count != 8'hFF)) ? count + 8'd1 : count;
    lastPix   = emit && (curX == LAST_X) && (curY == LAST_Y);
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state         <= IDLE;
      curData       <= '0;
      curX          <= '0;
      curY          <= '0;
      curDead       <= 1'b0;
      curLeftOk     <= 1'b0;
      count         <= '0;
      out_valid     <= 1'b0;
      out_data      <= '0;
      out_x         <= '0;
      out_y         <= '0;
      out_corrected <= 1'b0;
      frame_done    <= 1'b0;
      corr_count    <= '0;
      proto_err     <= 1'b0;
    end else begin
      out_valid     <= emit;
      out_corrected <= emit && curDead;
      frame_done    <= lastPix;
      if (emit) begin
        out_data <= emitData;
        out_x    <= curX;
        out_y    <= curY;
      end
      if (lastPix) begin
        corr_count <= countNext;
        count      <= '0;
      end else begin
        count <= countNext;
      end

      if ((state == HOLD) && pix_valid && !rightHit) proto_err <= 1'b1;

      // An out-of-order pixel starts over with no trustworthy left neighbour.
      if (pix_valid) begin
        curData   <= pix_data;
        curX      <= pix_x;
        curY      <= pix_y;
        curDead   <= pix_dead;
        curLeftOk <= (state != HOLD) || rightHit;
        state     <= (pix_x == LAST_X) ? FLUSH : HOLD;
      end else if (state == FLUSH) begin
        state <= IDLE;
      end
    end
  end

endmodule

// File: tb/tb_dead_pixel_corrector.sv
// Directed bench for dead_pixel_corrector: table-driven row vectors plus hand-written
// frame, protocol-error and mid-row reset sequences.
module tb_dead_pixel_corrector;
  localparam int W  = 32;
  localparam int H  = 24;
  localparam int DW = 16;

  logic          clk = 1'b0;
  logic          rst;
  logic          pix_valid;
  logic [DW-1:0] pix_data;
  logic [6:0]    pix_x;
  logic [5:0]    pix_y;
  logic          pix_dead;
  logic          out_valid;
  logic [DW-1:0] out_data;
  logic [6:0]    out_x;
  logic [5:0]    out_y;
  logic          out_corrected;
  logic          frame_done;
  logic [7:0]    corr_count;
  logic          proto_err;
  logic [40:0]   allOut;

  always #5 clk = ~clk;

  dead_pixel_corrector #(.W(W), .H(H), .DW(DW), .FILL('0)) dut (
    .clk(clk), .rst(rst),
    .pix_valid(pix_valid), .pix_data(pix_data), .pix_x(pix_x), .pix_y(pix_y),
    .pix_dead(pix_dead),
    .out_valid(out_valid), .out_data(out_data), .out_x(out_x), .out_y(out_y),
    .out_corrected(out_corrected), .frame_done(frame_done),
    .corr_count(corr_count), .proto_err(proto_err)
  );

  assign allOut = {out_valid, out_data, out_x, out_y, out_corrected, frame_done,
                   corr_count, proto_err};

  typedef struct {
    int            grp;
    int            x;
    logic [DW-1:0] data;
    logic          dead;
    logic [DW-1:0] expData;
    logic          expCorr;
  } vecT;

  typedef struct {
    logic [DW-1:0] data;
    logic [6:0]    x;
    logic [5:0]    y;
    logic          corr;
    time           t;
  } outT;

  vecT  vecs[20];
  outT  outQ[$];
  int   frameDones = 0;
  int   tests = 0;
  int   fails = 0;

  always @(posedge clk) begin
    #1;
    if (out_valid) outQ.push_back('{out_data, out_x, out_y, out_corrected, $time - 1});
    if (frame_done) frameDones++;
  end

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
    end
  endtask

  task automatic sendPix(input int x, input int y, input logic [DW-1:0] d,
                         input logic dead, output time t);
    pix_valid = 1'b1;
    pix_x     = 7'(x);
    pix_y     = 6'(y);
    pix_data  = d;
    pix_dead  = dead;
    @(posedge clk);
    t = $time;
    #1;
    pix_valid = 1'b0;
  endtask

  task automatic idle(input int n);
    repeat (n) begin
      @(posedge clk);
      #1;
    end
  endtask

  task automatic applyReset();
    rst = 1'b1;
    @(posedge clk);
    @(posedge clk);
    #1;
    rst = 1'b0;
    frameDones = 0;
    outQ.delete();
  endtask

  // Streams one full row; unlisted pixels are 100+x, clean, and must pass unchanged.
  task automatic runRow(input int g, input int y);
    logic [DW-1:0] d[W];
    logic [DW-1:0] e[W];
    logic          dd[W];
    logic          ec[W];
    time           tc[W];
    int            lateErr;
    int            n;
    for (int x = 0; x < W; x++) begin
      d[x] = DW'(100 + x); e[x] = d[x]; dd[x] = 1'b0; ec[x] = 1'b0;
    end
    foreach (vecs[i]) begin
      if (vecs[i].grp == g) begin
        d[vecs[i].x]  = vecs[i].data;
        dd[vecs[i].x] = vecs[i].dead;
        e[vecs[i].x]  = vecs[i].expData;
        ec[vecs[i].x] = vecs[i].expCorr;
      end
    end
    outQ.delete();
    for (int x = 0; x < W; x++) sendPix(x, y, d[x], dd[x], tc[x]);
    idle(3);
    n = outQ.size();
    check($sformatf("row%0d count", g), 64'(n), 64'(W));
    lateErr = 0;
    for (int i = 0; i < n && i < W; i++) begin
      check($sformatf("row%0d x%0d", g, i),
            64'({outQ[i].x, outQ[i].y, outQ[i].corr, outQ[i].data}),
            64'({7'(i), 6'(y), ec[i], e[i]}));
      if (outQ[i].t - tc[i] != 10) lateErr++;
    end
    check($sformatf("row%0d latency", g), 64'(lateErr), 64'd0);
  endtask

  task automatic runFrame(input logic withDead);
    time t;
    logic dead;
    outQ.delete();
    for (int y = 0; y < H; y++) begin
      for (int x = 0; x < W; x++) begin
        dead = withDead && ((x == 3 && y == 2) || (x == 10 && y == 5) || (x == 31 && y == 23));
        sendPix(x, y, DW'(100 + x), dead, t);
      end
    end
    idle(3);
  endtask

  initial begin
    time t;
    int  n;
    vecs = '{
      '{1,  4, 16'd104,   1'b0, 16'd104,   1'b0},
      '{1,  5, 16'd999,   1'b1, 16'd105,   1'b1},
      '{1,  6, 16'd106,   1'b0, 16'd106,   1'b0},
      '{2,  0, 16'd7,     1'b1, 16'd50,    1'b1},
      '{2,  1, 16'd50,    1'b0, 16'd50,    1'b0},
      '{2, 30, 16'd70,    1'b0, 16'd70,    1'b0},
      '{2, 31, 16'd5,     1'b1, 16'd70,    1'b1},
      '{3,  9, 16'd20,    1'b0, 16'd20,    1'b0},
      '{3, 10, 16'd1,     1'b1, 16'd20,    1'b1},
      '{3, 11, 16'd2,     1'b1, 16'd30,    1'b1},
      '{3, 12, 16'd40,    1'b0, 16'd40,    1'b0},
      '{4,  0, 16'd9,     1'b1, 16'd0,     1'b1},
      '{4,  1, 16'd9,     1'b1, 16'd51,    1'b1},
      '{4,  2, 16'd102,   1'b0, 16'd102,   1'b0},
      '{4,  4, 16'd3,     1'b0, 16'd3,     1'b0},
      '{4,  5, 16'd8,     1'b1, 16'd4,     1'b1},
      '{4,  6, 16'd4,     1'b0, 16'd4,     1'b0},
      '{4,  9, 16'hFFFF,  1'b0, 16'hFFFF,  1'b0},
      '{4, 10, 16'd0,     1'b1, 16'hFFFF,  1'b1},
      '{4, 11, 16'hFFFF,  1'b0, 16'hFFFF,  1'b0}
    };

    rst = 1'b1; pix_valid = 1'b0; pix_data = '0; pix_x = '0; pix_y = '0; pix_dead = 1'b0;
    #2;
    check("reset outputs", 64'(allOut), 64'd0);
    repeat (2) @(posedge clk);
    #1;
    rst = 1'b0;

    for (int g = 0; g < 5; g++) runRow(g, g);

    applyReset();
    runFrame(1'b1);
    check("frame1 frame_done pulses", 64'(frameDones), 64'd1);
    check("frame1 corr_count", 64'(corr_count), 64'd3);
    check("frame1 proto_err", 64'(proto_err), 64'd0);
    n = outQ.size();
    check("frame1 output count", 64'(n), 64'(W * H));
    if (n == W * H) begin
      check("frame1 pixel (3,2)", 64'({outQ[2*W+3].corr, outQ[2*W+3].data}), 64'({1'b1, 16'd103}));
      check("frame1 last pixel", 64'({outQ[n-1].x, outQ[n-1].y, outQ[n-1].corr, outQ[n-1].data}),
            64'({7'd31, 6'd23, 1'b1, 16'd130}));
    end
    runFrame(1'b0);
    check("frame2 frame_done pulses", 64'(frameDones), 64'd2);
    check("frame2 corr_count", 64'(corr_count), 64'd0);

    applyReset();
    for (int x = 0; x < 7; x++) sendPix(x, 3, (x == 6) ? 16'd60 : DW'(100 + x), 1'b0, t);
    sendPix(7, 3, 16'd999, 1'b1, t);
    check("proto_err before skip", 64'(proto_err), 64'd0);
    sendPix(9, 3, 16'd99, 1'b1, t);
    #1;
    check("proto_err after skip", 64'(proto_err), 64'd1);
    n = outQ.size();
    check("skip output count", 64'(n), 64'd8);
    if (n > 0)
      check("x7 emitted without right", 64'({outQ[n-1].x, outQ[n-1].corr, outQ[n-1].data}),
            64'({7'd7, 1'b1, 16'd60}));
    sendPix(10, 3, 16'd40, 1'b0, t);
    #1;
    n = outQ.size();
    check("post-skip output count", 64'(n), 64'd9);
    if (n > 0)
      check("x9 fresh left unusable", 64'({outQ[n-1].x, outQ[n-1].corr, outQ[n-1].data}),
            64'({7'd9, 1'b1, 16'd40}));
    check("proto_err sticky", 64'(proto_err), 64'd1);

    rst = 1'b1;
    #2;
    check("outputs during mid-row reset", 64'(allOut), 64'd0);
    n = outQ.size();
    @(posedge clk);
    @(posedge clk);
    #1;
    rst = 1'b0;
    idle(4);
    check("pending pixel discarded", 64'(outQ.size()), 64'(n));
    check("outputs after reset", 64'(allOut), 64'd0);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
